// File: rtl/lbdr_pkg.sv
// Shared types and constants for the LBDR routing unit.
// Optional feature macro: LBDR_DEROUTE_EN (adds the deroute table).
package lbdr_pkg;

  // Flit type encodings
  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  // Port indices into the one-hot request vector
  localparam int unsigned P_N = 0;
  localparam int unsigned P_E = 1;
  localparam int unsigned P_W = 2;
  localparam int unsigned P_S = 3;
  localparam int unsigned P_L = 4;

  // Rxy: [0]Rne [1]Rnw [2]Ren [3]Res [4]Rwn [5]Rws [6]Rse [7]Rsw
  typedef logic [7:0] rxy_t;
  // Cx: [0]N [1]E [2]W [3]S
  typedef logic [3:0] cx_t;
  // Deroute table: 2-bit port code per direction, [1:0]N [3:2]E [5:4]W [7:6]S
  typedef logic [7:0] drt_t;
  // One-hot port request {L,S,W,E,N}
  typedef logic [4:0] port_vec_t;

  typedef enum logic {
    ST_IDLE,
    ST_PKT
  } state_t;

endpackage

// File: rtl/lbdr_route_calc.sv
// Combinational LBDR route computation: one-hot port request plus
// unroutable flag. Optional macro: LBDR_DEROUTE_EN.
module lbdr_route_calc
  import lbdr_pkg::*;
#(
  parameter int unsigned COORD_W = 2
) (
  input  rxy_t                   rxy,
  input  cx_t                    cx,
`ifdef LBDR_DEROUTE_EN
  input  drt_t                   drt,
`endif
  input  logic [2*COORD_W-1:0]   cur_addr,
  input  logic [2*COORD_W-1:0]   dst_addr,
  output port_vec_t              port_oh,
  output logic                   unroute
);

  logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
  logic n1, s1, e1, w1;
  logic n, e, w, s, l;

  assign x_cur = cur_addr[COORD_W-1:0];
  assign y_cur = cur_addr[2*COORD_W-1:COORD_W];
  assign x_dst = dst_addr[COORD_W-1:0];
  assign y_dst = dst_addr[2*COORD_W-1:COORD_W];

  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  assign n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1])) & cx[0];
  assign e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3])) & cx[1];
  assign w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5])) & cx[2];
  assign s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7])) & cx[3];
  assign l = ~n1 & ~e1 & ~w1 & ~s1;

  // Priority select N>E>W>S keeps the request one-hot; deroute as fallback
  always_comb begin
    logic [1:0] dsel;
    port_oh = '0;
    unroute = 1'b0;
    dsel    = 2'd0;
    if (l)      port_oh[P_L] = 1'b1;
    else if (n) port_oh[P_N] = 1'b1;
    else if (e) port_oh[P_E] = 1'b1;
    else if (w) port_oh[P_W] = 1'b1;
    else if (s) port_oh[P_S] = 1'b1;
    else begin
`ifdef LBDR_DEROUTE_EN
      if (n1)      dsel = drt[1:0];
      else if (e1) dsel = drt[3:2];
      else if (w1) dsel = drt[5:4];
      else         dsel = drt[7:6];
      if (cx[dsel]) port_oh[dsel] = 1'b1;
      else          unroute       = 1'b1;
`else
      unroute = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/lbdr_route_unit.sv
// Packet-aware LBDR routing stage with runtime-writable Rxy/Cx/address.
// Optional macro: LBDR_DEROUTE_EN (adds Drt_rst/cfg_drt deroute table).
module lbdr_route_unit
  import lbdr_pkg::*;
#(
  parameter int unsigned COORD_W   = 2,
  parameter int unsigned FLIT_ID_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             Rxy_rst,
  input  logic [3:0]             Cx_rst,
  input  logic [2*COORD_W-1:0]   cur_addr_rst,
`ifdef LBDR_DEROUTE_EN
  input  logic [7:0]             Drt_rst,
  input  logic [7:0]             cfg_drt,
`endif
  input  logic                   cfg_we,
  input  logic [7:0]             cfg_rxy,
  input  logic [3:0]             cfg_cx,
  input  logic [2*COORD_W-1:0]   cfg_cur_addr,
  input  logic                   empty,
  input  logic [FLIT_ID_W-1:0]   flit_id,
  input  logic [2*COORD_W-1:0]   dst_addr,
  output logic                   Nport,
  output logic                   Eport,
  output logic                   Wport,
  output logic                   Sport,
  output logic                   Lport,
  output logic                   busy,
  output logic                   err_proto,
  output logic                   err_unroute
);

  state_t               state;
  rxy_t                 rxy_q;
  cx_t                  cx_q;
  logic [2*COORD_W-1:0] cur_q;
  port_vec_t            ports_q;
  logic                 drain;
  port_vec_t            route;
  logic                 unroute;
  logic                 is_hdr, is_pay, is_tail;
`ifdef LBDR_DEROUTE_EN
  drt_t                 drt_q;
`endif

  assign is_hdr  = flit_id == FLIT_ID_W'(FLIT_HEADER);
  assign is_pay  = flit_id == FLIT_ID_W'(FLIT_PAYLOAD);
  assign is_tail = flit_id == FLIT_ID_W'(FLIT_TAIL);

  lbdr_route_calc #(.COORD_W(COORD_W)) u_calc (
    .rxy      (rxy_q),
    .cx       (cx_q),
`ifdef LBDR_DEROUTE_EN
    .drt      (drt_q),
`endif
    .cur_addr (cur_q),
    .dst_addr (dst_addr),
    .port_oh  (route),
    .unroute  (unroute)
  );

  // Packet FSM, config registers and registered port/status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      ports_q     <= '0;
      busy        <= 1'b0;
      drain       <= 1'b0;
      err_proto   <= 1'b0;
      err_unroute <= 1'b0;
      rxy_q       <= Rxy_rst;
      cx_q        <= Cx_rst;
      cur_q       <= cur_addr_rst;
`ifdef LBDR_DEROUTE_EN
      drt_q       <= Drt_rst;
`endif
    end else begin
      err_unroute <= 1'b0;
      drain       <= 1'b0;
      // The tail drain cycle is time-based: the clear happens even when
      // empty is high, and a header in this same cycle overrides it below.
      if (drain) begin
        ports_q <= '0;
        busy    <= 1'b0;
      end
      if (cfg_we) begin
        if (state == ST_IDLE) begin
          rxy_q <= cfg_rxy;
          cx_q  <= cfg_cx;
          cur_q <= cfg_cur_addr;
`ifdef LBDR_DEROUTE_EN
          drt_q <= cfg_drt;
`endif
        end else begin
          err_proto <= 1'b1;
        end
      end
      if (!empty) begin
        unique case (state)
          ST_IDLE: begin
            if (is_hdr) begin
              if (!unroute) begin
                ports_q <= route;
                busy    <= 1'b1;
                state   <= ST_PKT;
              end else begin
                ports_q     <= '0;
                busy        <= 1'b0;
                err_unroute <= 1'b1;
              end
            end else begin
              err_proto <= 1'b1;
            end
          end
          ST_PKT: begin
            if (is_hdr) begin
              err_proto <= 1'b1;
              // A replacement header with no legal port abandons the packet
              if (!unroute) begin
                ports_q <= route;
              end else begin
                ports_q     <= '0;
                busy        <= 1'b0;
                err_unroute <= 1'b1;
                state       <= ST_IDLE;
              end
            end else if (is_tail) begin
              state <= ST_IDLE;
              drain <= 1'b1;
            end else if (!is_pay) begin
              err_proto <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign Nport = ports_q[P_N];
  assign Eport = ports_q[P_E];
  assign Wport = ports_q[P_W];
  assign Sport = ports_q[P_S];
  assign Lport = ports_q[P_L];

endmodule

// File: tb/tb_lbdr_route_unit.sv
// Self-checking bench for lbdr_route_unit (COORD_W=2). Honours LBDR_DEROUTE_EN.
module tb_lbdr_route_unit;
  import lbdr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Rxy_rst = 8'h3C;
  logic [3:0] Cx_rst = 4'hF;
  logic [3:0] cur_addr_rst = 4'h5;
  logic       cfg_we;
  logic [7:0] cfg_rxy = 8'h3C;
  logic [3:0] cfg_cx;
  logic [3:0] cfg_cur_addr = 4'h5;
  logic       empty;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic       Nport, Eport, Wport, Sport, Lport, busy, err_proto, err_unroute;
`ifdef LBDR_DEROUTE_EN
  logic [7:0] Drt_rst = 8'h0C;
  logic [7:0] cfg_drt = 8'h0C;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  lbdr_route_unit #(.COORD_W(2), .FLIT_ID_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .Rxy_rst      (Rxy_rst),
    .Cx_rst       (Cx_rst),
    .cur_addr_rst (cur_addr_rst),
`ifdef LBDR_DEROUTE_EN
    .Drt_rst      (Drt_rst),
    .cfg_drt      (cfg_drt),
`endif
    .cfg_we       (cfg_we),
    .cfg_rxy      (cfg_rxy),
    .cfg_cx       (cfg_cx),
    .cfg_cur_addr (cfg_cur_addr),
    .empty        (empty),
    .flit_id      (flit_id),
    .dst_addr     (dst_addr),
    .Nport        (Nport),
    .Eport        (Eport),
    .Wport        (Wport),
    .Sport        (Sport),
    .Lport        (Lport),
    .busy         (busy),
    .err_proto    (err_proto),
    .err_unroute  (err_unroute)
  );

  always #5 clk = ~clk;

  // Port vector expectations {L,S,W,E,N}
  localparam logic [4:0] PN = 5'b00000;
  localparam logic [4:0] PE = 5'b00010;
  localparam logic [4:0] PW = 5'b00100;
  localparam logic [4:0] PS = 5'b01000;
  localparam logic [4:0] PL = 5'b10000;

  typedef struct {
    logic       emp;
    logic [2:0] fid;
    logic [3:0] dst;
    logic       we;
    logic [3:0] cx;
    logic [4:0] ports;
    logic       busy;
    logic       perr;
    logic       unr;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] ep, input logic eb,
                     input logic epe, input logic eu);
    logic [4:0] got;
    got = {Lport, Sport, Wport, Eport, Nport};
    n_cmp++;
    if (got !== ep) begin
      n_err++;
      $display("FAIL %s ports got %b want %b", nm, got, ep);
    end
    n_cmp++;
    if (busy !== eb) begin
      n_err++;
      $display("FAIL %s busy got %b want %b", nm, busy, eb);
    end
    n_cmp++;
    if (err_proto !== epe) begin
      n_err++;
      $display("FAIL %s err_proto got %b want %b", nm, err_proto, epe);
    end
    n_cmp++;
    if (err_unroute !== eu) begin
      n_err++;
      $display("FAIL %s err_unroute got %b want %b", nm, err_unroute, eu);
    end
  endtask

  task automatic flit(input logic e, input logic [2:0] f, input logic [3:0] d);
    empty    = e;
    flit_id  = f;
    dst_addr = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flit(1'b1, FLIT_PAYLOAD, 4'h0);
    cfg_we = 1'b0;
    tick();
    chk("reset", PN, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    cfg_we = 1'b0;
    cfg_cx = 4'hF;
    rst    = 1'b1;
    flit(1'b1, FLIT_PAYLOAD, 4'h0);
    //             emp   fid           dst   we    cx     ports busy  perr  unr
    vecs[0]  = '{1'b0, FLIT_HEADER,  4'hB, 1'b0, 4'hF,  PE, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, FLIT_PAYLOAD, 4'h0, 1'b0, 4'hF,  PE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, FLIT_HEADER,  4'h5, 1'b0, 4'hF,  PE, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, FLIT_PAYLOAD, 4'h0, 1'b0, 4'hF,  PE, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, FLIT_TAIL,    4'h0, 1'b0, 4'hF,  PE, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, FLIT_TAIL,    4'h0, 1'b0, 4'hF,  PN, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, FLIT_HEADER,  4'h0, 1'b0, 4'hF,  PW, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, FLIT_TAIL,    4'h0, 1'b0, 4'hF,  PW, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, FLIT_HEADER,  4'h5, 1'b0, 4'hF,  PL, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, FLIT_TAIL,    4'h0, 1'b0, 4'hF,  PL, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, FLIT_TAIL,    4'h0, 1'b0, 4'hF,  PN, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, FLIT_TAIL,    4'h0, 1'b1, 4'hD,  PN, 1'b0, 1'b0, 1'b0};
`ifdef LBDR_DEROUTE_EN
    vecs[12] = '{1'b0, FLIT_HEADER,  4'h7, 1'b0, 4'hD,  PS, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, FLIT_HEADER,  4'h7, 1'b0, 4'hD,  PS, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, FLIT_TAIL,    4'h0, 1'b0, 4'hD,  PS, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, FLIT_TAIL,    4'h0, 1'b0, 4'hD,  PN, 1'b0, 1'b0, 1'b0};
`else
    vecs[12] = '{1'b0, FLIT_HEADER,  4'h7, 1'b0, 4'hD,  PN, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b1, FLIT_HEADER,  4'h7, 1'b0, 4'hD,  PN, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, FLIT_TAIL,    4'h0, 1'b0, 4'hD,  PN, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, FLIT_TAIL,    4'h0, 1'b0, 4'hD,  PN, 1'b0, 1'b0, 1'b0};
`endif

    do_reset();

    for (int i = 0; i < 16; i++) begin
      flit(vecs[i].emp, vecs[i].fid, vecs[i].dst);
      cfg_we = vecs[i].we;
      cfg_cx = vecs[i].cx;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].ports, vecs[i].busy, vecs[i].perr, vecs[i].unr);
    end
    cfg_we = 1'b0;

    // Payload while idle: sticky protocol error, no port
    flit(1'b0, FLIT_PAYLOAD, 4'h0); tick(); chk("idle_payload", PN, 1'b0, 1'b1, 1'b0);
    flit(1'b1, FLIT_PAYLOAD, 4'h0); tick(); chk("perr_sticky", PN, 1'b0, 1'b1, 1'b0);
    do_reset();

    // Header inside a packet re-routes and flags a protocol error
    flit(1'b0, FLIT_HEADER, 4'hB); tick(); chk("pkt_hdr1", PE, 1'b1, 1'b0, 1'b0);
    flit(1'b0, FLIT_HEADER, 4'h0); tick(); chk("pkt_hdr2", PW, 1'b1, 1'b1, 1'b0);
    do_reset();

    // Config write during a packet is ignored
    flit(1'b0, FLIT_HEADER, 4'hB); tick(); chk("cw_hdr", PE, 1'b1, 1'b0, 1'b0);
    flit(1'b1, FLIT_HEADER, 4'h0); cfg_we = 1'b1; cfg_cx = 4'h0;
    tick(); chk("cw_pkt", PE, 1'b1, 1'b1, 1'b0);
    cfg_we = 1'b0;
    flit(1'b0, FLIT_TAIL, 4'h0); tick(); chk("cw_tail", PE, 1'b1, 1'b1, 1'b0);
    flit(1'b1, FLIT_TAIL, 4'h0); tick(); chk("cw_drain", PN, 1'b0, 1'b1, 1'b0);
    flit(1'b0, FLIT_HEADER, 4'hB); tick(); chk("cw_kept", PE, 1'b1, 1'b1, 1'b0);
    do_reset();

    // Reset mid-packet aborts and reloads config from the reset inputs
    flit(1'b1, FLIT_HEADER, 4'h0); cfg_we = 1'b1; cfg_cx = 4'hD;
    tick(); chk("rl_cfg", PN, 1'b0, 1'b0, 1'b0);
    cfg_we = 1'b0;
    flit(1'b0, FLIT_HEADER, 4'h0); tick(); chk("rl_hdr", PW, 1'b1, 1'b0, 1'b0);
    flit(1'b0, FLIT_PAYLOAD, 4'h0); tick(); chk("rl_pay", PW, 1'b1, 1'b0, 1'b0);
    rst = 1'b0; tick(); chk("rl_abort", PN, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    flit(1'b0, FLIT_HEADER, 4'hB); tick(); chk("rl_reload", PE, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lbdr_route_unit.md
# lbdr_route_unit

Parametrised, packet-aware successor to the minimal LBDR routing stage for the 2-D mesh router input port. It holds a runtime-writable copy of the routing (Rxy), connectivity (Cx) and own-address registers. On each HEADER flit it computes a one-hot output-port request, holds that request through PAYLOAD flits until the TAIL flit retires the packet, and flags protocol and unroutable-destination errors.

## Interface
- COORD_W, 2, bits per X/Y coordinate; addresses are 2*COORD_W wide, {y,x}
- FLIT_ID_W, 3, flit type field width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- Rxy_rst  in  8  routing bits loaded at reset: [0]Rne [1]Rnw [2]Ren [3]Res [4]Rwn [5]Rws [6]Rse [7]Rsw
- Cx_rst  in  4  connectivity loaded at reset: [0]N [1]E [2]W [3]S
- cur_addr_rst  in  2*COORD_W  own address loaded at reset
- cfg_we  in  1  runtime config write strobe
- cfg_rxy / cfg_cx / cfg_cur_addr  in  8 / 4 / 2*COORD_W  runtime config data
- empty  in  1  input FIFO empty; the flit is valid when low
- flit_id  in  FLIT_ID_W  HEADER / PAYLOAD / TAIL
- dst_addr  in  2*COORD_W  destination; sampled on HEADER only
- Nport, Eport, Wport, Sport, Lport  out  1 each  registered port request, at most one high
- busy  out  1  packet in progress
- err_proto  out  1  sticky protocol error
- err_unroute  out  1  pulse: the current header had no legal port

## Operation
- FSM states:
  - IDLE: no packet in progress.
  - PKT: a packet is in progress.
- Comparators:
  - N1 = y_dst<y_cur
  - S1 = y_cur<y_dst
  - E1 = x_cur<x_dst
  - W1 = x_dst<x_cur
  - All comparisons unsigned, COORD_W bits wide.
- Minimal port equations:
  - N = (N1&~E1&~W1 | N1&E1&Rne | N1&W1&Rnw)&Cn. E, W and S follow the same pattern with Ren/Res, Rwn/Rws and Rse/Rsw.
  - L = ~N1&~E1&~W1&~S1 (exact address match).
- If more than one of N/E/W/S evaluates true, priority is N>E>W>S, so the output stays one-hot.
- IDLE + valid HEADER:
  - If a port is found: register the request and go to PKT.
  - If no port is found: all ports 0, err_unroute pulses for 1 cycle, stay IDLE, flit discarded.
- PKT + valid PAYLOAD: hold the request.
- PKT + valid TAIL: hold the request this cycle, then clear the ports and go to IDLE.
- PKT + valid HEADER: set err_proto, recompute the route from the new header, stay in PKT.
- IDLE + valid PAYLOAD/TAIL: set err_proto, ports stay 0.
- empty high: no state change; ports hold (they are not cleared, unlike the minimal stage).
- cfg_we: applied in IDLE only. In PKT the write is ignored and err_proto is set. A write and a header in the same IDLE cycle: the route uses the old config; the new config takes effect next cycle.
- err_proto is sticky until reset.

## Timing
- Reset (rst==0 at an edge):
  - All ports, busy, err_proto and err_unroute go to 0; state goes to IDLE.
  - Rxy, Cx and cur_addr load from the *_rst inputs.
  - Reset mid-packet aborts the packet immediately.
- Header accepted at edge t → port request valid after edge t+1 and busy=1.
- TAIL accepted at edge t → ports remain high through cycle t+1 and are 0 after edge t+2 (one cycle of tail drain).
- A TAIL at t followed by a HEADER at t+1 is legal. The new request is visible after edge t+2 with no idle gap beyond the drain cycle.
- Config write at edge t is used by a header sampled at edge t+1 or later.

## Configuration
- LBDR_DEROUTE_EN defined:
  - Adds input Drt_rst[7:0] and cfg_drt[7:0]: two bits per primary direction (N,E,W,S), encoding 0=N 1=E 2=W 3=S.
  - If the minimal result is empty and the destination is non-local, the first true comparator in N>E>W>S order selects the deroute port. That port is used if its C bit is set; otherwise err_unroute fires.
- LBDR_DEROUTE_EN undefined: the ports and logic are absent and the block is minimal only.

## Structure
- Shared package lbdr_pkg holds:
  - Flit-type constants HEADER/PAYLOAD/TAIL.
  - The FSM state enum.
  - Port-index constants.
  - Typedefs for the Rxy and Cx bit vectors.
- One sub-module: lbdr_route_calc. It is combinational and computes the one-hot port vector and the unroutable flag from config, cur_addr and dst_addr. The parent owns the FSM and all registers.

## Test plan
All scenarios use COORD_W=2. Reset load is Rxy=8'h3C, Cx=4'hF, cur_addr=4'h5 (x=1, y=1).
- Header dst=4'hB → Eport=1 after 1 cycle. Two payloads hold it. Tail → Eport=0 after the drain cycle, busy=0.
- Header dst=4'h0 → Wport=1. Header dst=4'h5 → Lport=1.
- Runtime write cfg_cx=4'hD in IDLE, then header dst=4'h7:
  - Macro off → err_unroute pulse, no port, busy=0.
  - Macro on with Drt N-slot=... E-slot=3 (S) → Sport=1.
- Payload in IDLE → err_proto=1, ports 0. Header in PKT → err_proto=1 and the route is updated.
- cfg_we during PKT → ignored and err_proto=1. rst=0 mid-packet → all outputs 0 on the next edge; config reloads from the *_rst inputs.
